alu_mult_seq: RTL

- Multi-cycle controller that implements MULT/MULTU by sequencing one 32-bit ALU instance through shift-add iterations.
- The block owns that ALU instance, drives its opcode and operands each cycle, and collects the 64-bit product into HI/LO registers.
- Sits beside the execute stage. The pipeline stalls on busy and reads hi/lo after done.

---
 rtl/alu_mult_seq_pkg.sv | 31 +++
 rtl/alu.sv | 37 +++
 rtl/alu_mult_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mult_seq_pkg.sv
// ============================================================================
// Module  : alu_mult_seq_pkg
// Brief   : Shared defines for the ALU and its multi-cycle MULT/MULTU sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alu_mult_seq_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'h5;

    localparam int MULT_ST_W = 3;

    localparam logic [MULT_ST_W-1:0] MULT_ST_IDLE  = 3'd0;
    localparam logic [MULT_ST_W-1:0] MULT_ST_RUN   = 3'd1;
    localparam logic [MULT_ST_W-1:0] MULT_ST_DONE  = 3'd2;
    localparam logic [MULT_ST_W-1:0] MULT_ST_NEGA  = 3'd3;
    localparam logic [MULT_ST_W-1:0] MULT_ST_NEGB  = 3'd4;
    localparam logic [MULT_ST_W-1:0] MULT_ST_FIXLO = 3'd5;
    localparam logic [MULT_ST_W-1:0] MULT_ST_FIXHI = 3'd6;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module  : alu
// Brief   : Combinational 32-bit integer ALU with zero flag (no carry out).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu
    import alu_mult_seq_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [ALU_OP_W-1:0]  op_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    output logic [WORD_SIZE-1:0] result_o,
    output logic                 zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_OP_ADDU: result_o = a_i + b_i;
            ALU_OP_SUBU: result_o = a_i - b_i;
            ALU_OP_AND:  result_o = a_i & b_i;
            ALU_OP_OR:   result_o = a_i | b_i;
            ALU_OP_XOR:  result_o = a_i ^ b_i;
            ALU_OP_SLTU: result_o = WORD_SIZE'(a_i < b_i);
            default:     result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/alu_mult_seq.sv
// ============================================================================
// Module  : alu_mult_seq
// Brief   : Shift-add MULT/MULTU sequencer driving one shared ALU into HI/LO.
//           Optional signed support enabled by defining MULT_SIGNED_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int MSB = WORD_SIZE - 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_SIZE - 1);

    logic [MULT_ST_W-1:0] state_q, state_d;
    logic [WORD_SIZE-1:0] mcand_q, mcand_d;
    logic [WORD_SIZE-1:0] hi_q, hi_d;
    logic [WORD_SIZE-1:0] lo_q, lo_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef MULT_SIGNED_EN
    logic                 sgn_q, sgn_d;
    logic                 neg_q, neg_d;
    logic                 lzero_q, lzero_d;
`endif

    logic [ALU_OP_W-1:0]  alu_op;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [WORD_SIZE-1:0] alu_res;
    logic                 alu_zero;
    logic                 w_unused_zero;
    logic                 w_carry;

    alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign w_unused_zero = alu_zero;
    // The ALU has no carry out; an unsigned add wrapped iff the sum is below an addend.
    assign w_carry = (alu_res < hi_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MULT_ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            lzero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
`ifdef MULT_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            lzero_q <= lzero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
`ifdef MULT_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        lzero_d = lzero_q;
`endif
        case (state_q)
            MULT_ST_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                    sgn_d   = signed_op;
                    neg_d   = a[MSB] ^ b[MSB];
                    lzero_d = 1'b0;
                    state_d = signed_op ? MULT_ST_NEGA : MULT_ST_RUN;
`else
                    state_d = MULT_ST_RUN;
`endif
                end
            end
            MULT_ST_RUN: begin
                hi_d  = {w_carry, alu_res[MSB:1]};
                lo_d  = {alu_res[0], lo_q[MSB:1]};
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LAST_ITER) begin
`ifdef MULT_SIGNED_EN
                    state_d = sgn_q ? MULT_ST_FIXLO : MULT_ST_DONE;
`else
                    state_d = MULT_ST_DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            MULT_ST_NEGA: begin
                if (mcand_q[MSB]) mcand_d = alu_res;
                state_d = MULT_ST_NEGB;
            end
            MULT_ST_NEGB: begin
                if (lo_q[MSB]) lo_d = alu_res;
                state_d = MULT_ST_RUN;
            end
            MULT_ST_FIXLO: begin
                if (neg_q) begin
                    lo_d    = alu_res;
                    lzero_d = (lo_q == '0);
                end
                state_d = MULT_ST_FIXHI;
            end
            MULT_ST_FIXHI: begin
                if (neg_q) hi_d = alu_res;
                state_d = MULT_ST_DONE;
            end
`endif
            MULT_ST_DONE: state_d = MULT_ST_IDLE;
            default:      state_d = MULT_ST_IDLE;
        endcase
    end

    always_comb begin
        alu_op = ALU_OP_ADDU;
        alu_a  = '0;
        alu_b  = '0;
        busy   = (state_q != MULT_ST_IDLE);
        done   = (state_q == MULT_ST_DONE);
        case (state_q)
            MULT_ST_RUN: begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? mcand_q : '0;
            end
`ifdef MULT_SIGNED_EN
            MULT_ST_NEGA: begin
                alu_op = ALU_OP_SUBU;
                alu_b  = mcand_q;
            end
            MULT_ST_NEGB, MULT_ST_FIXLO: begin
                alu_op = ALU_OP_SUBU;
                alu_b  = lo_q;
            end
            // Upper word of a 64-bit negate: ~hi plus the borrow out of the low word.
            MULT_ST_FIXHI: begin
                alu_a = ~hi_q;
                alu_b = WORD_SIZE'(lzero_q);
            end
`endif
            default: ;
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

`default_nettype wire
